ccff_bitstream_loader: RTL and testbench



---
 rtl/ccff_bitstream_loader.sv | 212 +++++++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: configuration-chain writer.
// Takes configuration words over a valid/ready stream and shifts them MSB-first into the
// ccff chain head. It also drives the per-bit shift enable that gates prog_clk to the chain.
// Optional build macro CCFF_LOADER_VERIFY_EN adds a recirculating verify pass. That pass
// compares a CRC-16-CCITT of the bits returned on ccff_tail against a CRC of the bits that
// were loaded.
module ccff_bitstream_loader #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WORD_W - 1);

`ifdef CCFF_LOADER_VERIFY_EN
  typedef enum logic [1:0] {StIdle, StLoad, StVerify, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;
`endif

  state_e state_q, state_d;

  logic [WORD_W-1:0] shreg_q;
  logic              sh_valid_q;
  logic [WORD_W-1:0] hold_q;
  logic              hold_valid_q;
  logic [IDX_W-1:0]  bit_idx_q;   // bit position within the word in shreg
  logic [CNT_W-1:0]  bit_cnt_q;   // chain bits shifted in LOAD, reused as VERIFY cycle count

  logic in_load;
  logic shift;
  logic last_bit;
  logic chain_full;
  logic accept;
  logic start_load;

  assign in_load    = (state_q == StLoad);
  assign shift      = in_load && sh_valid_q;
  assign last_bit   = shift && (bit_idx_q == LastIdx);
  assign chain_full = shift && (bit_cnt_q == LastBit);
  assign cfg_ready  = in_load && !hold_valid_q;
  assign accept     = cfg_valid && cfg_ready;
  assign start_load = start && ((state_q == StIdle) || (state_q == StDone));
  assign done       = (state_q == StDone);

`ifdef CCFF_LOADER_VERIFY_EN
  logic        in_verify;
  logic        verify_last;
  logic [15:0] crc_load_q;
  logic [15:0] crc_tail_q;
  logic [15:0] crc_tail_next;
  logic        error_q;

  // One MSB-first step of CRC-16-CCITT (poly 0x1021).
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign in_verify     = (state_q == StVerify);
  assign verify_last   = in_verify && (bit_cnt_q == LastBit);
  assign crc_tail_next = crc16_step(crc_tail_q, ccff_tail);

  // During verify the chain is closed into a loop so its contents survive the pass.
  assign ccff_head     = in_verify ? ccff_tail : shreg_q[WORD_W-1];
  assign ccff_shift_en = shift || in_verify;
  assign busy          = in_load || in_verify;
  assign error         = error_q;

  // CRC accumulators and sticky error flag.
  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      crc_load_q <= 16'hFFFF;
      crc_tail_q <= 16'hFFFF;
      error_q    <= 1'b0;
    end else if (start_load) begin
      crc_load_q <= 16'hFFFF;
      crc_tail_q <= 16'hFFFF;
      error_q    <= 1'b0;
    end else begin
      if (shift) begin
        crc_load_q <= crc16_step(crc_load_q, shreg_q[WORD_W-1]);
      end
      if (in_verify) begin
        crc_tail_q <= crc_tail_next;
      end
      if (verify_last && (crc_tail_next != crc_load_q)) begin
        error_q <= 1'b1;
      end
    end
  end
`else
  logic unused_tail;

  assign unused_tail   = ccff_tail;
  assign ccff_head     = shreg_q[WORD_W-1];
  assign ccff_shift_en = shift;
  assign busy          = in_load;
  assign error         = 1'b0;
`endif

  // State register.
  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        if (chain_full) begin
`ifdef CCFF_LOADER_VERIFY_EN
          state_d = StVerify;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef CCFF_LOADER_VERIFY_EN
      StVerify: begin
        if (verify_last) state_d = StDone;
      end
`endif
      StDone: begin
        if (start) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  // Shift/hold datapath: refill shreg on the edge its last bit leaves so words stream gap-free.
  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      shreg_q      <= '0;
      sh_valid_q   <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      bit_idx_q    <= '0;
      bit_cnt_q    <= '0;
    end else if (start_load) begin
      shreg_q      <= '0;
      sh_valid_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      bit_idx_q    <= '0;
      bit_cnt_q    <= '0;
    end else if (in_load) begin
      if (chain_full) begin
        // Chain is full: leftover bits of the final word and any held word are dropped.
        shreg_q      <= '0;
        sh_valid_q   <= 1'b0;
        hold_valid_q <= 1'b0;
        bit_idx_q    <= '0;
        bit_cnt_q    <= '0;
      end else begin
        if (shift) begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        if (!sh_valid_q || last_bit) begin
          bit_idx_q <= '0;
          if (hold_valid_q) begin
            shreg_q      <= hold_q;
            sh_valid_q   <= 1'b1;
            hold_valid_q <= 1'b0;
          end else if (accept) begin
            shreg_q    <= cfg_data;
            sh_valid_q <= 1'b1;
          end else begin
            // Underrun: chain stalls until the next word arrives.
            shreg_q    <= '0;
            sh_valid_q <= 1'b0;
          end
        end else begin
          shreg_q   <= shreg_q << 1;
          bit_idx_q <= bit_idx_q + 1'b1;
          if (accept) begin
            hold_q       <= cfg_data;
            hold_valid_q <= 1'b1;
          end
        end
      end
`ifdef CCFF_LOADER_VERIFY_EN
    end else if (in_verify) begin
      bit_cnt_q <= verify_last ? '0 : bit_cnt_q + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Self-checking bench for ccff_bitstream_loader (WORD_W=8, CHAIN_LEN=20, so the last word is
// partial). The chain is modelled as a plain shift register. Expected head bits come from the
// word list, and expected shift cycles come from word acceptance times.
module tb_ccff_bitstream_loader;

  localparam int W  = 8;
  localparam int L  = 20;
  localparam int NW = (L + W - 1) / W;

  logic         prog_clk = 1'b0;
  logic         pReset_n = 1'b0;
  logic         start = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         inject = 1'b0;
  logic [W-1:0] cfg_data = '0;
  logic         cfg_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, error;
  logic [L-1:0] chain = '0;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int done_cyc = -1;
  int vlen = 0;
  bit mon_en = 1'b0;

  logic         seen[$];
  int           shcyc[$];
  logic [W-1:0] words[NW];
  int           gaps[NW];
  int           acc[NW];

  ccff_bitstream_loader #(
    .WORD_W   (W),
    .CHAIN_LEN(L)
  ) dut (
    .prog_clk     (prog_clk),
    .pReset_n     (pReset_n),
    .start        (start),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) cyc <= cyc + 1;

  // Chain model: new bit enters at bit 0, oldest bit leaves from the top.
  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[L-2:0], ccff_head};
  assign ccff_tail = chain[L-1] ^ inject;

  // Record every shifted head bit and the cycle it was presented in.
  always @(negedge prog_clk) begin
    if (mon_en && ccff_shift_en) begin
      seen.push_back(ccff_head);
      shcyc.push_back(cyc);
    end
    if (mon_en && done && done_cyc < 0) done_cyc = cyc;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge prog_clk);
    #1;
  endtask

  function automatic logic exp_bit(input int k);
    logic [W-1:0] w;
    w = words[k / W];
    return w[W - 1 - (k % W)];
  endfunction

  task automatic push_word(input logic [W-1:0] w, output int acc_cyc);
    int k;
    cfg_data  = w;
    cfg_valid = 1'b1;
    k = 0;
    while (!cfg_ready && k < 100) begin
      step();
      k++;
    end
    check_eq("ready_for_word", 32'(cfg_ready), 32'd1);
    step();
    cfg_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic run_load(input bit pulse_start, input bit do_inject);
    int k;
    int s;
    int prev_end;
    int expcyc[L];
    logic [L-1:0] exp_chain;
    seen.delete();
    shcyc.delete();
    done_cyc = -1;
    mon_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    check_eq("ready_after_start", 32'(cfg_ready), 32'd1);
    check_eq("done_after_start", 32'(done), 32'd0);
    check_eq("error_after_start", 32'(error), 32'd0);
    for (int i = 0; i < NW; i++) begin
      repeat (gaps[i]) step();
      if (pulse_start && i == 1) begin
        start = 1'b1;
        step();
        start = 1'b0;
      end
      push_word(words[i], acc[i]);
    end
    k = 0;
    while (!done && k < 300) begin
      inject = do_inject && (seen.size() == L + 3);
      step();
      k++;
    end
    inject = 1'b0;
    check_eq("done_seen", 32'(done), 32'd1);

    // Each word starts shifting when accepted or when the previous word drains, whichever is later.
    prev_end = -1000;
    for (int i = 0; i < NW; i++) begin
      s = (acc[i] > prev_end) ? acc[i] : prev_end;
      for (int b = 0; b < W; b++) begin
        if (i * W + b < L) expcyc[i * W + b] = s + b;
      end
      prev_end = s + W;
    end
    for (int j = 0; j < L; j++) exp_chain[L - 1 - j] = exp_bit(j);

    for (int j = 0; j < L; j++) begin
      check_eq($sformatf("head_bit%0d", j), (j < seen.size()) ? 32'(seen[j]) : 'x,
               32'(exp_bit(j)));
      check_eq($sformatf("shift_cyc%0d", j), (j < shcyc.size()) ? 32'(shcyc[j]) : 'x,
               32'(expcyc[j]));
    end
    check_eq("num_shifts", 32'(seen.size()), 32'(L + vlen));
    check_eq("done_cycle", 32'(done_cyc), 32'(expcyc[L-1] + 1 + vlen));
    check_eq("error_final", 32'(error), 32'(do_inject));
`ifdef CCFF_LOADER_VERIFY_EN
    if (!do_inject) begin
      for (int j = 0; j < L; j++) begin
        check_eq($sformatf("verify_bit%0d", j),
                 (L + j < seen.size()) ? 32'(seen[L + j]) : 'x, 32'(exp_bit(j)));
        check_eq($sformatf("verify_cyc%0d", j),
                 (L + j < shcyc.size()) ? 32'(shcyc[L + j]) : 'x, 32'(expcyc[L-1] + 1 + j));
      end
    end
`endif
    if (!do_inject) check_eq("chain_contents", 32'(chain), 32'(exp_chain));

    // Extra words offered in DONE must not be taken.
    cfg_data  = W'($urandom);
    cfg_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      check_eq("ready_in_done", 32'(cfg_ready), 32'd0);
    end
    cfg_valid = 1'b0;
    check_eq("done_held", 32'(done), 32'd1);
    check_eq("busy_in_done", 32'(busy), 32'd0);
    check_eq("shift_en_in_done", 32'(ccff_shift_en), 32'd0);
    mon_en = 1'b0;
  endtask

  initial begin
    int k;
    int dummy;
`ifdef CCFF_LOADER_VERIFY_EN
    vlen = L;
`endif
    // Reset state, with cfg_valid asserted to show it is ignored.
    cfg_valid = 1'b1;
    cfg_data  = 8'hFF;
    repeat (3) step();
    check_eq("rst_ready", 32'(cfg_ready), 32'd0);
    check_eq("rst_head", 32'(ccff_head), 32'd0);
    check_eq("rst_shift_en", 32'(ccff_shift_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    pReset_n = 1'b1;
    step();
    check_eq("idle_ready", 32'(cfg_ready), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    cfg_valid = 1'b0;

    // Back-to-back words.
    words = '{8'hA5, 8'h3C, 8'hF0};
    gaps  = '{0, 0, 0};
    run_load(1'b0, 1'b0);

    // Underrun gap before the second word.
    words = '{8'hA5, 8'h3C, 8'h9F};
    gaps  = '{0, 10, 0};
    run_load(1'b0, 1'b0);

    // start pulsed while busy is ignored.
    words = '{8'h5A, 8'hC3, 8'h81};
    gaps  = '{1, 0, 2};
    run_load(1'b1, 1'b0);

    // Reset after 5 bits of a load.
    mon_en = 1'b1;
    seen.delete();
    shcyc.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    push_word(8'hA5, dummy);
    k = 0;
    while (seen.size() < 5 && k < 50) begin
      step();
      k++;
    end
    pReset_n = 1'b0;
    step();
    check_eq("midrst_ready", 32'(cfg_ready), 32'd0);
    check_eq("midrst_head", 32'(ccff_head), 32'd0);
    check_eq("midrst_shift_en", 32'(ccff_shift_en), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_error", 32'(error), 32'd0);
    pReset_n = 1'b1;
    mon_en = 1'b0;
    step();
    words = '{8'h12, 8'hED, 8'h7B};
    gaps  = '{0, 3, 9};
    run_load(1'b0, 1'b0);

`ifdef CCFF_LOADER_VERIFY_EN
    // Corrupt one returning bit during verify.
    words = '{8'hA5, 8'h3C, 8'h60};
    gaps  = '{0, 0, 0};
    run_load(1'b0, 1'b1);
`endif

    // Randomised loads, each restarted from DONE.
    for (int t = 0; t < 15; t++) begin
      for (int i = 0; i < NW; i++) begin
        words[i] = W'($urandom);
        gaps[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : 0;
      end
      run_load(($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
